// File: rtl/conv2d_pkg.sv
//------------------------------------------------------------------------------
// conv2d_pkg : shared FSM encoding and default geometry for conv_window_generator
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_PIXEL_WIDTH = 16;
  localparam int DEF_IMG_WIDTH   = 128;
  localparam int DEF_IMG_HEIGHT  = 128;

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
//------------------------------------------------------------------------------
// line_buffer : one image row of delay; dout is the value pushed DEPTH pushes ago
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_buffer
  import conv2d_pkg::*;
#(
  parameter int WIDTH = DEF_PIXEL_WIDTH,
  parameter int DEPTH = DEF_IMG_WIDTH
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_window_generator.sv
//------------------------------------------------------------------------------
// conv_window_generator : raster pixel stream to registered 3x3 windows.
// Macro WINGEN_SAME_PAD_EN emits every centre with zero padding; otherwise
// only fully interior windows are emitted.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_generator
  import conv2d_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [9*PIXEL_WIDTH-1:0]      win_flat,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          frame_done
);

  localparam int VR_W  = $clog2(IMG_HEIGHT + 1);
  localparam int VC_W  = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [VR_W-1:0] LAST_VR    = VR_W'(IMG_HEIGHT);
  localparam logic [VR_W-1:0] LAST_IN_VR = VR_W'(IMG_HEIGHT - 1);
  localparam logic [VC_W-1:0] LAST_VC    = VC_W'(IMG_WIDTH);

  state_t                   state;
  logic [VR_W-1:0]          vr;
  logic [VC_W-1:0]          vc;
  logic [9*PIXEL_WIDTH-1:0] win_q, win_next;
  logic [PIXEL_WIDTH-1:0]   lb1_out, lb2_out, col_top, col_mid, col_bot;
  logic                     in_col, input_step, slot_free, step_fire, emit, lb_en;

  assign in_col     = (vc < LAST_VC);
  assign input_step = (vr < LAST_VR) && in_col;
  assign slot_free  = !win_valid || win_ready;
  assign s_ready    = rst && slot_free && (state == IDLE || state == STREAM) && input_step;
  assign step_fire  = input_step ? (s_valid && s_ready)
                                 : (slot_free && (state == STREAM || state == FLUSH));

`ifdef WINGEN_SAME_PAD_EN
  assign emit = (vr != '0) && (vc != '0);
`else
  assign emit = (vr >= VR_W'(2)) && (vr < LAST_VR) && (vc >= VC_W'(2)) && (vc < LAST_VC);
`endif

  // Rows above the frame and the column past the right edge read as zero;
  // the zero column also clears the left edge of the next row's windows.
  assign col_top = (vr >= VR_W'(2) && in_col) ? lb2_out : '0;
  assign col_mid = (vr != '0 && in_col) ? lb1_out : '0;
  assign col_bot = input_step ? s_pixel : '0;
  assign lb_en   = step_fire && in_col;

  line_buffer #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk (clk), .en (lb_en), .din (col_bot), .dout (lb1_out)
  );

  line_buffer #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
    .clk (clk), .en (lb_en), .din (lb1_out), .dout (lb2_out)
  );

  always_comb begin
    win_next = win_q;
    for (int r = 0; r < 3; r++) begin
      win_next[(9-3*r)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = win_q[(8-3*r)*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
      win_next[(8-3*r)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = win_q[(7-3*r)*PIXEL_WIDTH-1 -: PIXEL_WIDTH];
    end
    win_next[7*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = col_top;
    win_next[4*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = col_mid;
    win_next[1*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = col_bot;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vr         <= '0;
      vc         <= '0;
      win_q      <= '0;
      win_flat   <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (step_fire) begin
        win_q     <= win_next;
        win_valid <= emit;
        if (emit) begin
          win_flat <= win_next;
          win_row  <= ROW_W'(vr - 1'b1);
          win_col  <= COL_W'(vc - 1'b1);
        end
        case (state)
          IDLE:   state <= STREAM;
          STREAM: if (vr == LAST_IN_VR && vc == LAST_VC) state <= FLUSH;
          FLUSH:  if (vc == LAST_VC) state <= DONE;
          default: ;
        endcase
        // Counters park on the final step until DONE hands back to IDLE
        if (!(state == FLUSH && vc == LAST_VC)) begin
          if (vc == LAST_VC) begin
            vc <= '0;
            vr <= vr + 1'b1;
          end else begin
            vc <= vc + 1'b1;
          end
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
      if (state == DONE && slot_free) begin
        frame_done <= 1'b1;
        state      <= IDLE;
        vr         <= '0;
        vc         <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_generator.sv
//------------------------------------------------------------------------------
// tb_conv_window_generator : scoreboard bench for a 4x4 frame (either pad mode)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_generator;

  localparam int PW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef WINGEN_SAME_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [$clog2(H)-1:0] row;
    logic [$clog2(W)-1:0] col;
    logic [9*PW-1:0]      flat;
  } win_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [PW-1:0]    s_pixel;
  logic                    s_valid;
  logic                    s_ready;
  logic [9*PW-1:0]         win_flat;
  logic                    win_valid;
  logic                    win_ready;
  logic [$clog2(H)-1:0]    win_row;
  logic [$clog2(W)-1:0]    win_col;
  logic                    frame_done;

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   acc_cnt = 0;
  bit   mon_en = 1'b1;
  bit   stall_req = 1'b0;
  win_t exp_q[$];
  int   img[H*W];

  always #5 clk = ~clk;

  conv_window_generator #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .win_flat   (win_flat),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  task automatic check(input bit ok, input string name, input logic [147:0] act, input logic [147:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return '0;
    return PW'(img[r*W+c]);
  endfunction

  // Expected windows for an image whose pixels are base, base+1, ... row-major
  task automatic push_frame(input int base);
    win_t e;
    for (int i = 0; i < H*W; i++) img[i] = base + i;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (PAD || (r >= 1 && r <= H-2 && c >= 1 && c <= W-2)) begin
          e.row = ($clog2(H))'(r);
          e.col = ($clog2(W))'(c);
          for (int j = 0; j < 9; j++) e.flat[(9-j)*PW-1 -: PW] = pix(r - 1 + j/3, c - 1 + j%3);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send_pixels(input int base, input bit rnd, input int count);
    int guard;
    for (int i = 0; i < count; i++) begin
      guard = 0;
      forever begin
        @(negedge clk); #2;
        s_pixel = PW'(base + i);
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_valid && s_ready) break;
        guard++;
        if (guard > 100) begin
          check(1'b0, "pixel accept timeout", 148'(i), 148'(count));
          return;
        end
      end
    end
    @(negedge clk); #2;
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int base, input bit rnd);
    int fd0, acc0;
    bit seen;
    fd0  = fd_cnt;
    acc0 = acc_cnt;
    seen = 1'b0;
    push_frame(base);
    send_pixels(base, rnd, H*W);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk); #4;
      seen = (fd_cnt != fd0);
    end
    repeat (3) @(negedge clk);
    #4;
    check(fd_cnt - fd0 == 1, {tag, " frame_done pulses"}, 148'(fd_cnt - fd0), 148'(1));
    check(acc_cnt - acc0 == H*W, {tag, " pixels accepted"}, 148'(acc_cnt - acc0), 148'(H*W));
    check(exp_q.size() == 0, {tag, " windows outstanding"}, 148'(exp_q.size()), 148'(0));
    exp_q.delete();
  endtask

  // Monitor: pops the scoreboard on each handshake and polices stalled outputs
  initial begin : monitor
    win_t got, held, e;
    bit   held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk); #1;
      got = {win_row, win_col, win_flat};
      if (!rst) begin
        held_v = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (win_valid && !win_ready) begin
          check(!s_ready, "s_ready during stall", 148'(s_ready), 148'(0));
          if (held_v) check(got == held, "stalled window stable", 148'(got), 148'(held));
          held   = got;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (win_valid && win_ready && mon_en) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected window", 148'(got), 148'(0));
          end else begin
            e = exp_q.pop_front();
            check(got == e, "window", 148'(got), 148'(e));
          end
        end
      end
    end
  end

  initial begin : accept_counter
    forever begin
      @(negedge clk); #3;
      if (rst && s_valid && s_ready) acc_cnt++;
    end
  end

  // Consumer: always ready, except five cycles of back-pressure on centre (1,2)
  initial begin : ready_driver
    int stall_cnt;
    stall_cnt = 0;
    win_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_req && stall_cnt < 5 && win_valid && win_row == 2'd1 && win_col == 2'd2) begin
        win_ready = 1'b0;
        stall_cnt++;
      end else begin
        win_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst     = 1'b0;
    s_valid = 1'b0;
    s_pixel = '0;
    repeat (2) @(negedge clk);
    #4;
    check(win_valid == 1'b0,  "reset win_valid",  148'(win_valid),  148'(0));
    check(s_ready == 1'b0,    "reset s_ready",    148'(s_ready),    148'(0));
    check(frame_done == 1'b0, "reset frame_done", 148'(frame_done), 148'(0));
    check(win_flat == '0,     "reset win_flat",   148'(win_flat),   148'(0));
    check(win_row == '0 && win_col == '0, "reset win_row/col", 148'({win_row, win_col}), 148'(0));
    @(negedge clk);
    rst = 1'b1;

    run_frame("base", 1, 1'b0);

    stall_req = 1'b1;
    run_frame("stall", 1, 1'b0);
    stall_req = 1'b0;

    run_frame("random_valid", 1, 1'b1);

    mon_en = 1'b0;
    send_pixels(1, 1'b0, 7);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check(win_valid == 1'b0, "async reset win_valid", 148'(win_valid), 148'(0));
    check(s_ready == 1'b0,   "async reset s_ready",   148'(s_ready),   148'(0));
    check(win_flat == '0,    "async reset win_flat",  148'(win_flat),  148'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    run_frame("after_reset", 1, 1'b0);

    run_frame("negative", -16, 1'b0);
    run_frame("back_to_back", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_window_generator.md
CONV_WINDOW_GENERATOR -- requirements
Module: conv_window_generator

Interface
REQ-001 Parameter PIXEL_WIDTH, default 16: signed pixel width.
REQ-002 Parameter IMG_WIDTH, default 128: pixels per row.
REQ-003 Parameter IMG_HEIGHT, default 128: rows per frame.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 s_pixel  input  PIXEL_WIDTH  raster pixel, row-major, signed.
REQ-007 s_valid  input  1  s_pixel valid.
REQ-008 s_ready  output  1  generator accepts s_pixel this cycle.
REQ-009 win_flat  output  9*PIXEL_WIDTH  3x3 window; element j=3*row+col at bits [(9-j)*PIXEL_WIDTH-1 -: PIXEL_WIDTH], so x00 occupies the MSBs, matching kernel_flat packing.
REQ-010 win_valid  output  1  win_flat, win_row and win_col valid.
REQ-011 win_ready  input  1  consumer takes the window.
REQ-012 win_row, win_col  output  $clog2(IMG_HEIGHT), $clog2(IMG_WIDTH)  centre coordinate, i.e. the output BRAM address {win_row,win_col}.
REQ-013 frame_done  output  1  one-cycle pulse when the last window of a frame is accepted.

Function
REQ-014 Virtual raster: step counters vr in 0..IMG_HEIGHT and vc in 0..IMG_WIDTH advance row-major, giving (IMG_HEIGHT+1)*(IMG_WIDTH+1) steps per frame.
REQ-015 Step type: input step when vr<IMG_HEIGHT and vc<IMG_WIDTH (consumes one pixel); otherwise bubble step (inserts 0, consumes nothing).
REQ-016 slot_free = !win_valid || win_ready.
- An input step fires on s_valid && s_ready.
- A bubble step fires whenever slot_free.
REQ-017 s_ready = slot_free && (state==STREAM || state==IDLE) && current step is an input step.
REQ-018 Two line buffers of IMG_WIDTH entries plus a 3x3 shift window hold rows vr-2, vr-1 and vr. Out-of-image positions (row -1, row IMG_HEIGHT, col -1, col IMG_WIDTH) read as 0.
REQ-019 A step with vr>=1 and vc>=1 loads the window centred at (vr-1, vc-1) into the output registers and sets win_valid on the next edge. The output is registered, with 1-cycle latency from the step.
REQ-020 win_valid, win_flat, win_row and win_col stay stable while win_valid && !win_ready, and input is stalled.
REQ-021 FSM states:
- IDLE: counters 0, waiting for the first input step; goes to STREAM on that step.
- STREAM: goes to FLUSH after the step at (IMG_HEIGHT-1, IMG_WIDTH).
- FLUSH: row vr=IMG_HEIGHT, bubbles only, s_ready=0; goes to DONE after step (IMG_HEIGHT, IMG_WIDTH).
- DONE: waits for the final window to be accepted, pulses frame_done, then returns to IDLE.
REQ-022 Simultaneous win_ready and a new step in the same cycle: the old window retires and the new one loads, with no bubble.
REQ-023 Data passes through unmodified; no arithmetic. Counters wrap to 0 only via DONE->IDLE.

Reset
REQ-024 On rst low, immediately:
- win_valid=0, frame_done=0, s_ready=0, win_flat=0, win_row=0, win_col=0.
- Counters 0, state IDLE.
- Line buffer contents need not be cleared.
REQ-025 Reset mid-frame abandons the frame. The first pixel after rst rises is pixel (0,0).

Configuration
REQ-026 Macro WINGEN_SAME_PAD_EN defined: every centre is emitted, IMG_HEIGHT*IMG_WIDTH windows, zero padded.
REQ-027 Macro WINGEN_SAME_PAD_EN undefined:
- Windows containing any padded element are suppressed (win_valid not set; the step still advances).
- Output is (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
- frame_done fires on the last emitted window.

Structure
REQ-028 Shared package conv2d_pkg holds the FSM state encoding (IDLE, STREAM, FLUSH, DONE) and the default PIXEL_WIDTH, IMG_WIDTH and IMG_HEIGHT constants.
REQ-029 Sub-module line_buffer: single-clock FIFO-style shift row of IMG_WIDTH entries with enable, instantiated twice.

Verification
REQ-030 IMG 4x4, pixels 1..16, win_ready=1, SAME_PAD on:
- 16 windows in order.
- Window (0,0) = {0,0,0, 0,1,2, 0,5,6}.
- Window (3,3) = {11,12,0, 15,16,0, 0,0,0}.
- frame_done pulses once.
REQ-031 Same frame with SAME_PAD off: exactly 4 windows, centres (1,1)..(2,2). Window (1,1) = {1,2,3, 5,6,7, 9,10,11}.
REQ-032 win_ready held low for 5 cycles at window (1,2): outputs stay stable, s_ready=0 throughout, no pixel lost, sequence is identical to REQ-030.
REQ-033 s_valid toggling randomly at 50%: window contents and order are identical to REQ-030. Total accepted pixels is 16.
REQ-034 rst pulsed low after pixel 7: win_valid drops asynchronously. A following full frame of 1..16 reproduces REQ-030 exactly.
REQ-035 Two back-to-back frames: the second frame's window (0,0) contains no values from the first frame.
